pixel_bit_shift: RTL and testbench
==================================

PIXEL_BIT_SHIFT -- requirements
Module: pixel_bit_shift

Interface
REQ-001 SHALL have parameter PIX_WIDTH, default 24, meaning bits per pixel word.
REQ-002 SHALL have parameter RST_WIDTH, default 16, meaning width of the latch-time register.
REQ-003 SHALL have port clk_i  input  1  sole clock, all state updates on its rising edge.
REQ-004 SHALL have port rst_i  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port pix_vld_i  input  1  upstream pixel word valid.
REQ-006 SHALL have port pix_data_i  input  PIX_WIDTH  pixel word, transmitted MSB first.
REQ-007 SHALL have port pix_last_i  input  1  marks the final pixel of a frame; qualified by pix_vld_i.
REQ-008 SHALL have port pix_rdy_o  output  1  pixel input ready.
REQ-009 SHALL have port reg_rst_time_i  input  RST_WIDTH  latch (reset-code) duration in clk_i cycles.
REQ-010 SHALL have port bit_rdy_i  input  1  downstream waveform generator ready.
REQ-011 SHALL have port bit_vld_o  output  1  one-cycle bit strobe to the waveform generator.
REQ-012 SHALL have port bit_data_o  output  1  bit value, valid while bit_vld_o=1.
REQ-013 SHALL have port frame_done_o  output  1  one-cycle pulse at the end of the latch period.

Function
REQ-014 SHALL accept a pixel on any rising edge where pix_vld_i=1 and pix_rdy_o=1, storing data and last flag in a one-entry shadow buffer.
REQ-015 SHALL drive pix_rdy_o = NOT shadow_full, with no combinational path from pix_vld_i.
REQ-016 SHALL implement states IDLE, SEND, DRAIN, LATCH.
REQ-017 IDLE: if shadow full, move shadow to shift register and bit counter = PIX_WIDTH, clear shadow, go to SEND on the same edge.
REQ-018 SEND: on an edge where bit_rdy_i=1 and bit_vld_o=0, register bit_vld_o=1, bit_data_o=shift MSB, shift left by one, decrement counter.
REQ-019 SHALL force bit_vld_o=0 on the edge after every strobe; the strobe cycle is a hold-off, giving a minimum strobe pitch of 2 cycles.
REQ-020 SHALL hold bit_data_o stable from the strobe until the next strobe.
REQ-021 After the last bit of a word is issued: last flag=1 -> DRAIN; else shadow full -> reload per REQ-017 and stay in SEND, no extra gap; else -> IDLE.
REQ-022 DRAIN: on the first edge with bit_vld_o=0 and bit_rdy_i=1, load the latch counter with reg_rst_time_i and go to LATCH.
REQ-023 LATCH: decrement the counter each cycle; at counter=0, pulse frame_done_o for one cycle and go to IDLE; reg_rst_time_i=0 gives the pulse on the first LATCH cycle.
REQ-024 SHALL continue accepting one pixel into the shadow buffer during DRAIN and LATCH but SHALL issue no strobes until LATCH exits.
REQ-025 SHALL sample reg_rst_time_i only on DRAIN exit; changes during LATCH have no effect.
REQ-026 Latency: pixel accepted at edge k gives first strobe at edge k+2 if bit_rdy_i=1 (k+1 load, k+2 strobe).

Reset
REQ-027 While rst_i=1: state=IDLE, shadow empty, counters 0, bit_vld_o=0, bit_data_o=0, frame_done_o=0, pix_rdy_o=0.
REQ-028 SHALL raise pix_rdy_o on the first edge after rst_i deasserts.
REQ-029 Reset mid-word or mid-latch SHALL discard the shift register and shadow contents, with no strobe or frame_done_o afterwards until new pixels arrive.

Verification
REQ-030 Reset: rst_i pulsed at t=2 ns -> all outputs 0; pix_rdy_o=1 one edge after release.
REQ-031 Single word: pix_data_i=24'hA50F3C, last=0, bit_rdy_i tied 1 -> 24 strobes, pitch 2 cycles, bits 1010_0101_0000_1111_0011_1100, first strobe 2 edges after accept.
REQ-032 Back-to-back: two words 24'hFFFFFF and 24'h000000 offered continuously -> 48 strobes at a uniform 2-cycle pitch; pix_rdy_o low while shadow full.
REQ-033 Backpressure: bit_rdy_i held 0 for 10 cycles mid-word -> no strobes, bit_data_o stable; strobing resumes 1 edge after bit_rdy_i=1, no bit lost or repeated.
REQ-034 Frame end: last=1, reg_rst_time_i=100 -> frame_done_o pulses 100 cycles after DRAIN exit; reg_rst_time_i=0 -> pulse on the first LATCH cycle; a pixel queued during LATCH starts after the pulse.
REQ-035 Reset mid-word: rst_i asserted after the 7th strobe -> bit_vld_o=0 immediately, no further strobes, clean restart with the next pixel.

Source files
------------

// File: rtl/pixel_bit_shift.sv
// Serialises pixel words MSB-first into one-cycle bit strobes for a waveform generator,
// then holds a latch (reset-code) period and pulses frame_done_o at the end of each frame.
module pixel_bit_shift #(
    parameter int PIX_WIDTH = 24,
    parameter int RST_WIDTH = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 pix_vld_i,
    input  logic [PIX_WIDTH-1:0] pix_data_i,
    input  logic                 pix_last_i,
    output logic                 pix_rdy_o,
    input  logic [RST_WIDTH-1:0] reg_rst_time_i,
    input  logic                 bit_rdy_i,
    output logic                 bit_vld_o,
    output logic                 bit_data_o,
    output logic                 frame_done_o,
    output logic [1:0]           dbg_state_o
);

    localparam int CNT_W = $clog2(PIX_WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SEND  = 2'd1,
        DRAIN = 2'd2,
        LATCH = 2'd3
    } state_t;

    state_t               state_q, state_d;
    logic                 run_q, run_d;
    logic                 sh_full_q, sh_full_d;
    logic [PIX_WIDTH-1:0] sh_data_q, sh_data_d;
    logic                 sh_last_q, sh_last_d;
    logic [PIX_WIDTH-1:0] shift_q, shift_d;
    logic [CNT_W-1:0]     bit_cnt_q, bit_cnt_d;
    logic                 cur_last_q, cur_last_d;
    logic [RST_WIDTH-1:0] lat_cnt_q, lat_cnt_d;
    logic                 bit_vld_q, bit_vld_d;
    logic                 bit_data_q, bit_data_d;
    logic                 frame_done_q, frame_done_d;
    logic                 accept;
    logic                 load;

    // Handshake: a pixel transfers on a rising edge where pix_vld_i and pix_rdy_o are both 1;
    // pix_rdy_o depends only on registered state, never on pix_vld_i.
    assign pix_rdy_o    = run_q & ~sh_full_q;
    assign accept       = pix_vld_i & pix_rdy_o;
    assign bit_vld_o    = bit_vld_q;
    assign bit_data_o   = bit_data_q;
    assign frame_done_o = frame_done_q;
    assign dbg_state_o  = state_q;

    always_comb begin
        state_d      = state_q;
        run_d        = 1'b1;
        sh_full_d    = sh_full_q;
        sh_data_d    = sh_data_q;
        sh_last_d    = sh_last_q;
        shift_d      = shift_q;
        bit_cnt_d    = bit_cnt_q;
        cur_last_d   = cur_last_q;
        lat_cnt_d    = lat_cnt_q;
        bit_vld_d    = 1'b0;
        bit_data_d   = bit_data_q;
        frame_done_d = 1'b0;
        load         = 1'b0;

        if (accept) begin
            sh_full_d = 1'b1;
            sh_data_d = pix_data_i;
            sh_last_d = pix_last_i;
        end

        case (state_q)
            IDLE: begin
                if (sh_full_q) begin
                    load = 1'b1;
                end
            end
            SEND: begin
                // bit_cnt_q reaches zero only on the hold-off cycle after the final strobe,
                // so a reload here keeps the 2-cycle pitch across word boundaries.
                if (bit_cnt_q == '0) begin
                    if (cur_last_q) begin
                        state_d = DRAIN;
                    end else if (sh_full_q) begin
                        load = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end else if (bit_rdy_i && !bit_vld_q) begin
                    bit_vld_d  = 1'b1;
                    bit_data_d = shift_q[PIX_WIDTH-1];
                    shift_d    = shift_q << 1;
                    bit_cnt_d  = bit_cnt_q - CNT_W'(1);
                end
            end
            DRAIN: begin
                if (bit_rdy_i && !bit_vld_q) begin
                    lat_cnt_d = reg_rst_time_i;
                    state_d   = LATCH;
                end
            end
            LATCH: begin
                // A latch time of 0 or 1 both end on the first LATCH cycle.
                if (lat_cnt_q <= RST_WIDTH'(1)) begin
                    lat_cnt_d    = '0;
                    frame_done_d = 1'b1;
                    state_d      = IDLE;
                end else begin
                    lat_cnt_d = lat_cnt_q - RST_WIDTH'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (load) begin
            shift_d    = sh_data_q;
            cur_last_d = sh_last_q;
            bit_cnt_d  = CNT_W'(PIX_WIDTH);
            sh_full_d  = 1'b0;
            state_d    = SEND;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= IDLE;
            run_q        <= 1'b0;
            sh_full_q    <= 1'b0;
            sh_data_q    <= '0;
            sh_last_q    <= 1'b0;
            shift_q      <= '0;
            bit_cnt_q    <= '0;
            cur_last_q   <= 1'b0;
            lat_cnt_q    <= '0;
            bit_vld_q    <= 1'b0;
            bit_data_q   <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            run_q        <= run_d;
            sh_full_q    <= sh_full_d;
            sh_data_q    <= sh_data_d;
            sh_last_q    <= sh_last_d;
            shift_q      <= shift_d;
            bit_cnt_q    <= bit_cnt_d;
            cur_last_q   <= cur_last_d;
            lat_cnt_q    <= lat_cnt_d;
            bit_vld_q    <= bit_vld_d;
            bit_data_q   <= bit_data_d;
            frame_done_q <= frame_done_d;
        end
    end

endmodule

// File: tb/tb_pixel_bit_shift.sv
// Bench for pixel_bit_shift: directed vector table, multi-cycle corner sequences and a
// randomized run checked by a bit-level scoreboard with frame ordering.
module tb_pixel_bit_shift;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b0;
    logic        pix_vld_i = 1'b0;
    logic [23:0] pix_data_i = '0;
    logic        pix_last_i = 1'b0;
    logic        pix_rdy_o;
    logic [15:0] reg_rst_time_i = '0;
    logic        bit_rdy_i;
    logic        bit_vld_o;
    logic        bit_data_o;
    logic        frame_done_o;
    logic [1:0]  dbg_state_o;

    logic        rand_bp = 1'b0;
    logic        bp_rand = 1'b1;
    logic        man_rdy = 1'b1;

    assign bit_rdy_i = rand_bp ? bp_rand : man_rdy;

    pixel_bit_shift #(.PIX_WIDTH(24), .RST_WIDTH(16)) dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .pix_vld_i      (pix_vld_i),
        .pix_data_i     (pix_data_i),
        .pix_last_i     (pix_last_i),
        .pix_rdy_o      (pix_rdy_o),
        .reg_rst_time_i (reg_rst_time_i),
        .bit_rdy_i      (bit_rdy_i),
        .bit_vld_o      (bit_vld_o),
        .bit_data_o     (bit_data_o),
        .frame_done_o   (frame_done_o),
        .dbg_state_o    (dbg_state_o)
    );

    // clock / reset
    always #5 clk_i = ~clk_i;

    always @(negedge clk_i) bp_rand <= ($urandom_range(0, 3) != 0);

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // scoreboard: each entry is {frame id, bit}, pushed MSB-first on acceptance
    logic [16:0] exp_q[$];
    int   cyc = 0;
    int   frames_started = 0;
    int   done_cnt = 0;
    int   acc_cyc = 0;
    int   done_cyc = 0;
    int   st_cnt = 0, st_first = 0, st_last = 0, st_pmin = 0, st_pmax = 0;
    logic rdy_s = 1'b0;
    logic prev_vld = 1'b0;
    logic prev_done = 1'b0;
    logic last_bit = 1'b0;

    task automatic clear_stats();
        st_cnt  = 0;
        st_pmin = 1000000;
        st_pmax = 0;
    endtask

    always @(posedge clk_i) begin
        logic [16:0] e;
        cyc++;
        if (!rst_i && pix_vld_i && rdy_s) begin
            acc_cyc = cyc;
            for (int i = 23; i >= 0; i--) exp_q.push_back({frames_started[15:0], pix_data_i[i]});
            if (pix_last_i) frames_started++;
        end
        #1;
        rdy_s = pix_rdy_o;
        if (rst_i) begin
            exp_q.delete();
            frames_started = 0;
            done_cnt  = 0;
            prev_vld  = 1'b0;
            prev_done = 1'b0;
            last_bit  = 1'b0;
        end else begin
            if (bit_vld_o) begin
                check("strobe_pitch", {31'd0, prev_vld}, 32'd0);
                if (exp_q.size() == 0) begin
                    check("spurious_strobe", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("bit_data", {31'd0, bit_data_o}, {31'd0, e[0]});
                    check("frame_order", {16'd0, e[16:1]}, done_cnt);
                end
                if (st_cnt == 0) begin
                    st_first = cyc;
                end else begin
                    if (cyc - st_last < st_pmin) st_pmin = cyc - st_last;
                    if (cyc - st_last > st_pmax) st_pmax = cyc - st_last;
                end
                st_last = cyc;
                st_cnt++;
                last_bit = bit_data_o;
            end else begin
                check("bit_data_hold", {31'd0, bit_data_o}, {31'd0, last_bit});
            end
            if (frame_done_o) begin
                check("done_width", {31'd0, prev_done}, 32'd0);
                check("spurious_done", (done_cnt < frames_started) ? 32'd1 : 32'd0, 32'd1);
                done_cnt++;
                done_cyc = cyc;
            end
            prev_vld  = bit_vld_o;
            prev_done = frame_done_o;
        end
    end

    // drivers
    task automatic send_word(input logic [23:0] d, input logic l);
        logic ok;
        ok = 1'b0;
        @(negedge clk_i);
        pix_vld_i  = 1'b1;
        pix_data_i = d;
        pix_last_i = l;
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk_i);
            if (rdy_s) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("accept_timeout", 32'd1, 32'd0);
    endtask

    task automatic idle_in();
        @(negedge clk_i);
        pix_vld_i  = 1'b0;
        pix_last_i = 1'b0;
    endtask

    task automatic wait_quiet(input int budget);
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(posedge clk_i);
            #2;
            if (exp_q.size() == 0 && done_cnt == frames_started && pix_rdy_o) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("quiet_timeout", 32'd1, 32'd0);
        repeat (3) @(negedge clk_i);
    endtask

    task automatic wait_strobes(input int n);
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < 500; i++) begin
            @(posedge clk_i);
            #2;
            if (st_cnt >= n) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("strobe_wait_timeout", 32'd1, 32'd0);
    endtask

    typedef struct {
        logic [23:0] data;
        logic        last;
        logic [15:0] rst_time;
        int          exp_strobes;
        int          exp_lat;
        int          exp_pitch;
        int          exp_gap;
    } vec_t;

    vec_t vecs[6];

    initial begin
        int d0, c0, done0;
        logic b0;

        // gap = cycles from the last strobe to frame_done_o: hold-off, DRAIN, then max(N,1)
        vecs[0] = '{24'hA50F3C, 1'b0, 16'd0,   24, 2, 2, 0};
        vecs[1] = '{24'hA50F3C, 1'b1, 16'd100, 24, 2, 2, 102};
        vecs[2] = '{24'h123456, 1'b1, 16'd0,   24, 2, 2, 3};
        vecs[3] = '{24'hFFFFFF, 1'b1, 16'd1,   24, 2, 2, 3};
        vecs[4] = '{24'h000001, 1'b1, 16'd5,   24, 2, 2, 7};
        vecs[5] = '{24'h800000, 1'b0, 16'd9,   24, 2, 2, 0};

        // reset
        #2;
        rst_i = 1'b1;
        #1;
        check("rst_bit_vld", {31'd0, bit_vld_o}, 32'd0);
        check("rst_bit_data", {31'd0, bit_data_o}, 32'd0);
        check("rst_frame_done", {31'd0, frame_done_o}, 32'd0);
        check("rst_pix_rdy", {31'd0, pix_rdy_o}, 32'd0);
        repeat (2) @(negedge clk_i);
        rst_i = 1'b0;
        #1;
        check("rdy_before_edge", {31'd0, pix_rdy_o}, 32'd0);
        @(posedge clk_i);
        #1;
        check("rdy_after_release", {31'd0, pix_rdy_o}, 32'd1);

        // vector table
        for (int v = 0; v < 6; v++) begin
            clear_stats();
            done0 = done_cnt;
            reg_rst_time_i = vecs[v].rst_time;
            send_word(vecs[v].data, vecs[v].last);
            idle_in();
            wait_quiet(2000);
            check($sformatf("v%0d_strobes", v), st_cnt, vecs[v].exp_strobes);
            check($sformatf("v%0d_latency", v), st_first - acc_cyc, vecs[v].exp_lat);
            check($sformatf("v%0d_pitch_min", v), st_pmin, vecs[v].exp_pitch);
            check($sformatf("v%0d_pitch_max", v), st_pmax, vecs[v].exp_pitch);
            if (vecs[v].last) begin
                check($sformatf("v%0d_done_gap", v), done_cyc - st_last, vecs[v].exp_gap);
                check($sformatf("v%0d_done_cnt", v), done_cnt, done0 + 1);
            end else begin
                check($sformatf("v%0d_no_done", v), done_cnt, done0);
            end
        end

        // back-to-back words
        clear_stats();
        send_word(24'hFFFFFF, 1'b0);
        send_word(24'h000000, 1'b0);
        idle_in();
        repeat (3) @(negedge clk_i);
        check("b2b_rdy_low_full", {31'd0, pix_rdy_o}, 32'd0);
        wait_quiet(2000);
        check("b2b_strobes", st_cnt, 48);
        check("b2b_pitch_min", st_pmin, 2);
        check("b2b_pitch_max", st_pmax, 2);

        // backpressure mid-word
        clear_stats();
        send_word(24'hA50F3C, 1'b0);
        idle_in();
        wait_strobes(5);
        @(negedge clk_i);
        man_rdy = 1'b0;
        c0 = st_cnt;
        b0 = bit_data_o;
        repeat (10) @(negedge clk_i);
        check("bp_no_strobes", st_cnt, c0);
        check("bp_data_stable", {31'd0, bit_data_o}, {31'd0, b0});
        man_rdy = 1'b1;
        @(posedge clk_i);
        #2;
        check("bp_resume", {31'd0, bit_vld_o}, 32'd1);
        wait_quiet(2000);
        check("bp_strobes", st_cnt, 24);

        // pixel queued during DRAIN/LATCH starts only after frame_done_o
        clear_stats();
        reg_rst_time_i = 16'd20;
        send_word(24'h5A5A5A, 1'b1);
        idle_in();
        wait_strobes(24);
        clear_stats();
        send_word(24'h0F0F0F, 1'b0);
        idle_in();
        reg_rst_time_i = 16'd3;
        wait_quiet(2000);
        check("queued_after_done", st_first - done_cyc, 2);
        check("queued_strobes", st_cnt, 24);

        // reset after the 7th strobe
        clear_stats();
        send_word(24'h3C3C3C, 1'b1);
        idle_in();
        wait_strobes(7);
        rst_i = 1'b1;
        #1;
        check("midrst_bit_vld", {31'd0, bit_vld_o}, 32'd0);
        check("midrst_pix_rdy", {31'd0, pix_rdy_o}, 32'd0);
        repeat (3) @(negedge clk_i);
        rst_i = 1'b0;
        clear_stats();
        repeat (40) @(negedge clk_i);
        check("midrst_no_strobes", st_cnt, 0);
        check("midrst_no_done", done_cnt, 0);
        check("midrst_rdy", {31'd0, pix_rdy_o}, 32'd1);
        send_word(24'hC3C3C3, 1'b0);
        idle_in();
        wait_quiet(2000);
        check("midrst_restart_strobes", st_cnt, 24);
        check("midrst_restart_latency", st_first - acc_cyc, 2);

        // randomized traffic with random backpressure and latch times
        rand_bp = 1'b1;
        for (int w = 0; w < 40; w++) begin
            reg_rst_time_i = 16'($urandom_range(0, 6));
            send_word(24'($urandom), ($urandom_range(0, 4) == 0));
            if ($urandom_range(0, 2) == 0) begin
                idle_in();
                repeat ($urandom_range(1, 30)) @(negedge clk_i);
            end
        end
        idle_in();
        @(negedge clk_i);
        rand_bp = 1'b0;
        wait_quiet(5000);
        check("rand_queue_empty", exp_q.size(), 0);
        check("rand_frames_done", done_cnt, frames_started);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
